stage_sequencer: RTL and testbench

STAGE_SEQUENCER -- requirements
Module: stage_sequencer

---
 rtl/stage_sequencer.sv | 168 ++++++++++++++++
 tb/tb_stage_sequencer.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stage_sequencer.sv
// Sequences chained processing stages over one shared edge BRAM, with per-stage
// skip, watchdog timeout and optional per-frame rerun.
module stage_sequencer #(
  parameter int unsigned NUM_STAGES     = 4,
  parameter int unsigned ADDR_W         = 19,
  parameter int unsigned DATA_W         = 3,
  parameter int unsigned TIMEOUT_CYCLES = 2000000
) (
  input  logic                         clk_25mhz,
  input  logic                         reset,
  input  logic                         go,
  input  logic [NUM_STAGES-1:0]        skip_mask,
  input  logic                         auto_rerun,
  input  logic                         frame_sync,
  input  logic [NUM_STAGES-1:0]        stage_done,
  input  logic [NUM_STAGES*ADDR_W-1:0] stage_addra,
  input  logic [NUM_STAGES*ADDR_W-1:0] stage_addrb,
  input  logic [NUM_STAGES*ADDR_W-1:0] stage_rgb_addr,
  input  logic [NUM_STAGES*DATA_W-1:0] stage_dina,
  input  logic [NUM_STAGES-1:0]        stage_wea,
  input  logic [ADDR_W-1:0]            vga_addr,
  output logic [NUM_STAGES-1:0]        stage_start,
  output logic [ADDR_W-1:0]            bram_addra,
  output logic [DATA_W-1:0]            bram_dina,
  output logic                         bram_wea,
  output logic [ADDR_W-1:0]            bram_addrb,
  output logic [ADDR_W-1:0]            rgb_addr,
  output logic                         busy,
  output logic [2:0]                   cur_stage,
  output logic                         pipeline_done,
  output logic                         error,
  output logic [2:0]                   err_stage
);

  localparam int unsigned WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  // Compare before incrementing so ERROR lands TIMEOUT_CYCLES cycles after the start pulse
  localparam logic [WD_W-1:0] WD_LIM = WD_W'((TIMEOUT_CYCLES > 1) ? TIMEOUT_CYCLES - 2 : 0);

  typedef enum logic [2:0] {S_IDLE, S_START, S_RUN, S_DISPLAY, S_ERROR} state_t;

  state_t                r_state;
  logic [2:0]            r_cur_stage;
  logic [NUM_STAGES-1:0] r_skip;
  logic [WD_W-1:0]       r_wdog;
  logic [2:0]            r_err_stage;
  logic [NUM_STAGES-1:0] r_stage_start;
  logic                  r_busy;
  logic                  r_pipeline_done;
  logic                  r_error;

  logic [2:0] w_first_idx;
  logic       w_first_ok;
  logic [2:0] w_next_idx;
  logic       w_next_ok;
  logic [7:0] w_done8;
  logic       w_done;
  logic       w_restart;

  // Lowest unskipped stage for a fresh run, and next unskipped stage after the current one
  always_comb begin
    w_first_idx = 3'd0;
    w_first_ok  = 1'b0;
    w_next_idx  = 3'd0;
    w_next_ok   = 1'b0;
    for (int i = int'(NUM_STAGES) - 1; i >= 0; i--) begin
      if (!skip_mask[i]) begin
        w_first_idx = 3'(i);
        w_first_ok  = 1'b1;
      end
      if (!r_skip[i] && (3'(i) > r_cur_stage)) begin
        w_next_idx = 3'(i);
        w_next_ok  = 1'b1;
      end
    end
  end

  assign w_done8   = 8'(stage_done);
  assign w_done    = w_done8[r_cur_stage];
  assign w_restart = (go && (r_state == S_IDLE || r_state == S_DISPLAY || r_state == S_ERROR)) ||
                     (r_state == S_DISPLAY && auto_rerun && frame_sync);

  always_ff @(posedge clk_25mhz or posedge reset) begin
    if (reset) begin
      r_state         <= S_IDLE;
      r_cur_stage     <= 3'd0;
      r_skip          <= '0;
      r_wdog          <= '0;
      r_err_stage     <= 3'd0;
      r_stage_start   <= '0;
      r_busy          <= 1'b0;
      r_pipeline_done <= 1'b0;
      r_error         <= 1'b0;
    end else begin
      r_stage_start   <= '0;
      r_pipeline_done <= 1'b0;
      if (w_restart) begin
        r_skip  <= skip_mask;
        r_error <= 1'b0;
        if (w_first_ok) begin
          r_state       <= S_START;
          r_cur_stage   <= w_first_idx;
          r_stage_start <= NUM_STAGES'(1) << w_first_idx;
          r_busy        <= 1'b1;
        end else begin
          r_state         <= S_DISPLAY;
          r_pipeline_done <= 1'b1;
          r_busy          <= 1'b0;
        end
      end else begin
        case (r_state)
          S_START: begin
            r_state <= S_RUN;
            r_wdog  <= '0;
          end
          S_RUN: begin
            if (w_done) begin
              if (w_next_ok) begin
                r_state       <= S_START;
                r_cur_stage   <= w_next_idx;
                r_stage_start <= NUM_STAGES'(1) << w_next_idx;
              end else begin
                r_state         <= S_DISPLAY;
                r_pipeline_done <= 1'b1;
                r_busy          <= 1'b0;
              end
            end else if (r_wdog == WD_LIM) begin
              r_state     <= S_ERROR;
              r_error     <= 1'b1;
              r_err_stage <= r_cur_stage;
              r_busy      <= 1'b0;
            end else begin
              r_wdog <= r_wdog + WD_W'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Active stage owns the BRAM ports while sequencing; video playback owns them otherwise
  always_comb begin
    bram_addra = '0;
    bram_dina  = '0;
    bram_wea   = 1'b0;
    bram_addrb = vga_addr;
    rgb_addr   = vga_addr;
    if (r_state == S_START || r_state == S_RUN) begin
      for (int i = 0; i < int'(NUM_STAGES); i++) begin
        if (r_cur_stage == 3'(i)) begin
          bram_addra = stage_addra[i*ADDR_W +: ADDR_W];
          bram_dina  = stage_dina[i*DATA_W +: DATA_W];
          bram_addrb = stage_addrb[i*ADDR_W +: ADDR_W];
          rgb_addr   = stage_rgb_addr[i*ADDR_W +: ADDR_W];
          bram_wea   = (r_state == S_RUN) && stage_wea[i];
        end
      end
    end
  end

  assign stage_start   = r_stage_start;
  assign busy          = r_busy;
  assign cur_stage     = r_cur_stage;
  assign pipeline_done = r_pipeline_done;
  assign error         = r_error;
  assign err_stage     = r_err_stage;

endmodule

// File: tb/tb_stage_sequencer.sv
// Scoreboard bench for stage_sequencer: directed runs push expected start/done/error
// events; a negedge monitor pops and compares them as the DUT emits them.
module tb_stage_sequencer;

  localparam int unsigned NS = 4;
  localparam int unsigned AW = 19;
  localparam int unsigned DW = 3;

  localparam logic [1:0] EV_START = 2'd1;
  localparam logic [1:0] EV_DONE  = 2'd2;
  localparam logic [1:0] EV_ERR   = 2'd3;

  logic             clk_25mhz = 1'b0;
  logic             reset;
  logic             go;
  logic [NS-1:0]    skip_mask;
  logic             auto_rerun;
  logic             frame_sync;
  logic [NS-1:0]    stage_done;
  logic [NS*AW-1:0] stage_addra;
  logic [NS*AW-1:0] stage_addrb;
  logic [NS*AW-1:0] stage_rgb_addr;
  logic [NS*DW-1:0] stage_dina;
  logic [NS-1:0]    stage_wea;
  logic [AW-1:0]    vga_addr;
  logic [NS-1:0]    stage_start;
  logic [AW-1:0]    bram_addra;
  logic [DW-1:0]    bram_dina;
  logic             bram_wea;
  logic [AW-1:0]    bram_addrb;
  logic [AW-1:0]    rgb_addr;
  logic             busy;
  logic [2:0]       cur_stage;
  logic             pipeline_done;
  logic             error;
  logic [2:0]       err_stage;

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [7:0] exp_q[$];
  logic [NS-1:0] resp_en;
  int         resp_cnt[NS];

  stage_sequencer #(
    .NUM_STAGES(NS), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(100)
  ) dut (
    .clk_25mhz(clk_25mhz), .reset(reset), .go(go), .skip_mask(skip_mask),
    .auto_rerun(auto_rerun), .frame_sync(frame_sync), .stage_done(stage_done),
    .stage_addra(stage_addra), .stage_addrb(stage_addrb), .stage_rgb_addr(stage_rgb_addr),
    .stage_dina(stage_dina), .stage_wea(stage_wea), .vga_addr(vga_addr),
    .stage_start(stage_start), .bram_addra(bram_addra), .bram_dina(bram_dina),
    .bram_wea(bram_wea), .bram_addrb(bram_addrb), .rgb_addr(rgb_addr), .busy(busy),
    .cur_stage(cur_stage), .pipeline_done(pipeline_done), .error(error), .err_stage(err_stage)
  );

  always #5 clk_25mhz = ~clk_25mhz;

  function automatic logic [7:0] mk_ev(input logic [1:0] t, input logic [2:0] idx);
    return {3'b000, t, idx};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_run(input logic [NS-1:0] skip);
    for (int i = 0; i < int'(NS); i++)
      if (!skip[i]) exp_q.push_back(mk_ev(EV_START, 3'(i)));
    exp_q.push_back(mk_ev(EV_DONE, 3'd0));
  endtask

  task automatic pulse_go(input logic [NS-1:0] m);
    @(negedge clk_25mhz);
    skip_mask = m;
    go = 1'b1;
    @(negedge clk_25mhz);
    go = 1'b0;
  endtask

  task automatic wait_empty(input string name, input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk_25mhz);
      n++;
    end
    chk(name, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic wait_start(input int idx, input int budget, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < budget; n++) begin
      @(negedge clk_25mhz);
      if (stage_start[idx]) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Stage model: done level rises 10 cycles after its start unless that stage is disabled
  always @(negedge clk_25mhz) begin
    for (int i = 0; i < int'(NS); i++) begin
      if (stage_start[i]) begin
        stage_done[i] = 1'b0;
        resp_cnt[i]   = resp_en[i] ? 10 : 0;
      end else if (resp_cnt[i] > 0) begin
        resp_cnt[i] = resp_cnt[i] - 1;
        if (resp_cnt[i] == 0) stage_done[i] = 1'b1;
      end
    end
  end

  // Monitor: every start pulse, done pulse and error entry must match the queue head
  logic prev_err = 1'b0;
  always @(negedge clk_25mhz) begin
    logic [7:0] act;
    logic       has_ev;
    has_ev = 1'b0;
    act    = 8'h00;
    if (stage_start != '0) begin
      chk("start_onehot", 32'($countones(stage_start)), 32'd1);
      for (int i = 0; i < int'(NS); i++)
        if (stage_start[i]) act = mk_ev(EV_START, 3'(i));
      chk("start_cur_stage", 32'(cur_stage), 32'(act[2:0]));
      has_ev = 1'b1;
    end else if (pipeline_done) begin
      act = mk_ev(EV_DONE, 3'd0);
      has_ev = 1'b1;
    end else if (error && !prev_err) begin
      act = mk_ev(EV_ERR, err_stage);
      has_ev = 1'b1;
    end
    prev_err = error;
    if (has_ev) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_event: got 0x%0h expected none at %0t", act, $time);
      end else begin
        chk("event", 32'(act), 32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    bit ok;
    int cnt;
    reset = 1'b1; go = 1'b0; skip_mask = '0; auto_rerun = 1'b0; frame_sync = 1'b0;
    stage_done = '0; stage_addra = '0; stage_addrb = '0; stage_rgb_addr = '0;
    stage_dina = '0; stage_wea = '0; vga_addr = 19'h00ABC; resp_en = 4'hF;
    for (int i = 0; i < int'(NS); i++) resp_cnt[i] = 0;

    repeat (3) @(negedge clk_25mhz);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_error", 32'(error), 0);
    chk("rst_cur_stage", 32'(cur_stage), 0);
    chk("rst_err_stage", 32'(err_stage), 0);
    chk("rst_stage_start", 32'(stage_start), 0);
    chk("rst_pipeline_done", 32'(pipeline_done), 0);
    chk("rst_bram_wea", 32'(bram_wea), 0);
    chk("rst_bram_addrb", 32'(bram_addrb), 32'h00ABC);
    chk("rst_rgb_addr", 32'(rgb_addr), 32'h00ABC);
    reset = 1'b0;
    repeat (10) @(negedge clk_25mhz);
    chk("idle_after_reset", 32'(busy), 0);

    // Full run, all stages; a go during RUN must be ignored
    push_run(4'b0000);
    pulse_go(4'b0000);
    repeat (3) @(negedge clk_25mhz);
    chk("busy_in_run", 32'(busy), 1);
    go = 1'b1;
    @(negedge clk_25mhz);
    go = 1'b0;
    wait_empty("full_run_drain", 300);
    chk("display_busy", 32'(busy), 0);
    vga_addr = 19'h1F00F;
    #1;
    chk("display_addrb", 32'(bram_addrb), 32'h1F00F);
    chk("display_rgb", 32'(rgb_addr), 32'h1F00F);
    chk("display_wea", 32'(bram_wea), 0);

    // Skip stages 0 and 2
    push_run(4'b0101);
    pulse_go(4'b0101);
    chk("skip_first_stage", 32'(cur_stage), 1);
    wait_start(3, 100, ok);
    chk("skip_reach_stage3", 32'(ok), 1);
    chk("skip_cur_stage3", 32'(cur_stage), 3);
    wait_empty("skip_drain", 100);

    // Everything skipped: straight to DISPLAY
    push_run(4'b1111);
    pulse_go(4'b1111);
    chk("allskip_done_pulse", 32'(pipeline_done), 1);
    chk("allskip_busy", 32'(busy), 0);
    wait_empty("allskip_drain", 5);

    // Routing while stage 1 runs (it hangs and times out)
    stage_addra[0*AW +: AW] = 19'h0AAAA;
    stage_addra[1*AW +: AW] = 19'h12345;
    stage_dina[0*DW +: DW]  = 3'd2;
    stage_dina[1*DW +: DW]  = 3'd5;
    stage_addrb[1*AW +: AW] = 19'h0BEEF;
    stage_rgb_addr[1*AW +: AW] = 19'h0CAFE;
    stage_wea = 4'b0011;
    resp_en = 4'b1101;
    exp_q.push_back(mk_ev(EV_START, 3'd0));
    exp_q.push_back(mk_ev(EV_START, 3'd1));
    exp_q.push_back(mk_ev(EV_ERR, 3'd1));
    pulse_go(4'b0000);
    wait_start(1, 100, ok);
    chk("reach_stage1", 32'(ok), 1);
    chk("start_wea_off", 32'(bram_wea), 0);
    chk("start_addra", 32'(bram_addra), 32'h12345);
    @(negedge clk_25mhz);
    chk("run1_addra", 32'(bram_addra), 32'h12345);
    chk("run1_wea", 32'(bram_wea), 1);
    chk("run1_dina", 32'(bram_dina), 5);
    chk("run1_addrb", 32'(bram_addrb), 32'h0BEEF);
    chk("run1_rgb", 32'(rgb_addr), 32'h0CAFE);
    stage_wea = 4'b0001;
    #1;
    chk("run1_other_wea", 32'(bram_wea), 0);
    wait_empty("stage1_timeout_drain", 200);
    chk("stage1_err_stage", 32'(err_stage), 1);

    // Stage 2 timeout timing, then go recovers from ERROR
    resp_en = 4'b1011;
    stage_wea = 4'hF;
    exp_q.push_back(mk_ev(EV_START, 3'd0));
    exp_q.push_back(mk_ev(EV_START, 3'd1));
    exp_q.push_back(mk_ev(EV_START, 3'd2));
    exp_q.push_back(mk_ev(EV_ERR, 3'd2));
    pulse_go(4'b0000);
    wait_start(2, 200, ok);
    chk("reach_stage2", 32'(ok), 1);
    cnt = 0;
    while (!error && cnt < 300) begin
      @(negedge clk_25mhz);
      cnt++;
    end
    chk("timeout_cycles", 32'(cnt), 100);
    chk("err_stage2", 32'(err_stage), 2);
    chk("err_wea", 32'(bram_wea), 0);
    chk("err_busy", 32'(busy), 0);
    chk("err_addrb", 32'(bram_addrb), 32'h1F00F);
    wait_empty("stage2_timeout_drain", 5);
    resp_en = 4'hF;
    push_run(4'b0000);
    pulse_go(4'b0000);
    chk("recover_start0", 32'(stage_start), 32'b0001);
    chk("recover_error_clr", 32'(error), 0);
    wait_empty("recover_drain", 300);

    // Auto rerun on frame_sync, coincident go gives a single restart
    push_run(4'b0000);
    @(negedge clk_25mhz);
    auto_rerun = 1'b1; frame_sync = 1'b1; go = 1'b1; skip_mask = 4'b0000;
    @(negedge clk_25mhz);
    frame_sync = 1'b0; go = 1'b0;
    chk("rerun_start0", 32'(stage_start), 32'b0001);
    wait_empty("rerun_drain", 300);
    auto_rerun = 1'b0;
    @(negedge clk_25mhz);
    frame_sync = 1'b1;
    @(negedge clk_25mhz);
    frame_sync = 1'b0;
    chk("no_rerun_when_off", 32'(busy), 0);

    // Asynchronous reset while stage 0 is running
    stage_wea = 4'b0001;
    exp_q.push_back(mk_ev(EV_START, 3'd0));
    pulse_go(4'b0000);
    @(negedge clk_25mhz);
    chk("pre_reset_wea", 32'(bram_wea), 1);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_busy", 32'(busy), 0);
    chk("async_rst_wea", 32'(bram_wea), 0);
    chk("async_rst_cur", 32'(cur_stage), 0);
    chk("async_rst_start", 32'(stage_start), 0);
    chk("async_rst_addrb", 32'(bram_addrb), 32'h1F00F);
    repeat (2) @(negedge clk_25mhz);
    reset = 1'b0;
    repeat (20) @(negedge clk_25mhz);
    chk("post_reset_idle", 32'(busy), 0);
    wait_empty("final_drain", 5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
